cnn_conv1_acc: RTL and testbench

Accumulate/requantize stage of the conv1 datapath, directly downstream of the signed 14x9 product multiplier. Consumes a stream of 24-bit signed products, sums one kernel window of TAPS products, adds a per-window bias, optionally applies ReLU, then rounds, shifts and saturates to the activation width fed to the next layer. Valid/ready handshake on both sides.

---
 rtl/cnn_conv1_pkg.sv | 22 ++
 rtl/cnn_conv1_requant.sv | 43 ++++
 rtl/cnn_conv1_acc.sv | 124 ++++++++++++
 tb/tb_cnn_conv1_acc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_conv1_pkg.sv
// cnn_conv1_pkg: default widths, window geometry, FSM states and output
// saturation bounds for the conv1 accumulate/requantize stage.
package cnn_conv1_pkg;

   localparam int unsigned PROD_W = 24;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned BIAS_W = 16;
   localparam int unsigned OUT_W  = 14;
   localparam int unsigned TAPS   = 25;
   localparam int unsigned SHIFT  = 8;

   // Saturation bounds of the default activation width
   localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
   localparam int OUT_MIN = -(1 << (OUT_W - 1));

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_FIN = 2'd1,
      ST_OUT = 2'd2
   } state_e;

endpackage

// File: rtl/cnn_conv1_requant.sv
// cnn_conv1_requant: combinational round-half-up, arithmetic shift, optional
// ReLU and saturation of the window accumulator to the activation width.
// Optional feature macro: CNN_CONV1_ACC_RELU_EN (clamp negatives to zero).
module cnn_conv1_requant #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned OUT_W = 14,
   parameter int unsigned SHIFT = 8
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] q_c
);

   // One guard bit keeps the rounding add from wrapping at the top of range
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam int unsigned SH_W  = EXT_W - SHIFT;

   localparam logic [EXT_W-1:0]       HALF    = EXT_W'(64'd1 << (SHIFT - 1));
   localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-(64'sd1 <<< (OUT_W - 1)));

   logic signed [EXT_W-1:0] rnd_c;
   logic signed [SH_W-1:0]  shf_c;
   logic signed [SH_W-1:0]  clip_c;

   // Round, shift, rectify and clamp
   always_comb begin
      rnd_c  = $signed({acc_i[ACC_W-1], acc_i} + HALF);
      shf_c  = SH_W'(rnd_c >>> SHIFT);
      clip_c = shf_c;
`ifdef CNN_CONV1_ACC_RELU_EN
      if (shf_c < 0) begin
         clip_c = '0;
      end
`endif
      if (clip_c > SAT_MAX) begin
         clip_c = SAT_MAX;
      end else if (clip_c < SAT_MIN) begin
         clip_c = SAT_MIN;
      end
      q_c = OUT_W'(clip_c);
   end

endmodule

// File: rtl/cnn_conv1_acc.sv
// cnn_conv1_acc: sums TAPS signed products per window plus a bias sampled on
// the first product, then requantizes to the activation width. Valid/ready on
// both sides; tap_err flags a prod_tlast that disagrees with the tap counter.
// Optional feature macro: CNN_CONV1_ACC_RELU_EN (ReLU before saturation).
module cnn_conv1_acc #(
   parameter int unsigned PROD_W = cnn_conv1_pkg::PROD_W,
   parameter int unsigned ACC_W  = cnn_conv1_pkg::ACC_W,
   parameter int unsigned BIAS_W = cnn_conv1_pkg::BIAS_W,
   parameter int unsigned OUT_W  = cnn_conv1_pkg::OUT_W,
   parameter int unsigned TAPS   = cnn_conv1_pkg::TAPS,
   parameter int unsigned SHIFT  = cnn_conv1_pkg::SHIFT
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [PROD_W-1:0] prod_tdata,
   input  logic              prod_tvalid,
   output logic              prod_tready,
   input  logic              prod_tlast,
   input  logic [BIAS_W-1:0] bias_data,
   output logic [OUT_W-1:0]  out_tdata,
   output logic              out_tvalid,
   input  logic              out_tready,
   output logic              tap_err
);

   import cnn_conv1_pkg::*;

   localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               prod_tready_q, prod_tready_d;
   logic               tap_err_q, tap_err_d;

   logic [ACC_W-1:0]   prod_ext_c;
   logic [ACC_W-1:0]   bias_ext_c;
   logic               is_last_c;
   logic [OUT_W-1:0]   requant_c;

   assign prod_ext_c = ACC_W'($signed(prod_tdata));
   assign bias_ext_c = ACC_W'($signed(bias_data));
   assign is_last_c  = (cnt_q == CNT_W'(TAPS - 1));

   cnn_conv1_requant #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc_i (acc_q),
      .q_c   (requant_c)
   );

   // Next-state, accumulate, requant capture and sticky error
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      tap_err_d   = tap_err_q;
      case (state_q)
         ST_ACC: begin
            if (prod_tvalid && prod_tready_q) begin
               acc_d = (cnt_q == '0) ? (bias_ext_c + prod_ext_c) : (acc_q + prod_ext_c);
               if (prod_tlast != is_last_c) begin
                  tap_err_d = 1'b1;
               end
               if (is_last_c) begin
                  cnt_d   = '0;
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_FIN: begin
            out_data_d  = requant_c;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_tready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
      // Ready is a registered decode of the state being entered
      prod_tready_d = (state_d == ST_ACC);
   end

   // State and datapath registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= ST_ACC;
         cnt_q         <= '0;
         acc_q         <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         prod_tready_q <= 1'b0;
         tap_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         prod_tready_q <= prod_tready_d;
         tap_err_q     <= tap_err_d;
      end
   end

   assign prod_tready = prod_tready_q;
   assign out_tdata   = out_data_q;
   assign out_tvalid  = out_valid_q;
   assign tap_err     = tap_err_q;

endmodule

// File: tb/tb_cnn_conv1_acc.sv
// tb_cnn_conv1_acc: directed windows against an arithmetic reference model
// (sum, round half up, shift, optional ReLU, clamp) with hand-pinned values.
// Honors CNN_CONV1_ACC_RELU_EN for expected results.
`timescale 1ns/1ps
module tb_cnn_conv1_acc;
   import cnn_conv1_pkg::*;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b1;
   logic [PROD_W-1:0] prod_tdata;
   logic              prod_tvalid;
   logic              prod_tready;
   logic              prod_tlast;
   logic [BIAS_W-1:0] bias_data;
   logic [OUT_W-1:0]  out_tdata;
   logic              out_tvalid;
   logic              out_tready;
   logic              tap_err;

   int     n_vec = 0;
   int     n_err = 0;
   longint cyc = 0;
   longint exp_q[$];
   bit     exp_err = 1'b0;
   bit     lat_chk = 1'b0;
   longint last_acc_cyc = 0;
   longint first_acc_cyc = 0;
   longint xfer_cyc = 0;
   bit     prev_valid = 1'b0;
   bit     prev_ready = 1'b0;
   logic [OUT_W-1:0] prev_data = '0;
   longint mon_e;

   cnn_conv1_acc dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .prod_tdata  (prod_tdata),
      .prod_tvalid (prod_tvalid),
      .prod_tready (prod_tready),
      .prod_tlast  (prod_tlast),
      .bias_data   (bias_data),
      .out_tdata   (out_tdata),
      .out_tvalid  (out_tvalid),
      .out_tready  (out_tready),
      .tap_err     (tap_err)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Reference: exact window sum, round half up, floor shift, ReLU, clamp
   function automatic longint model(input longint sum);
      longint v;
      v = (sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef CNN_CONV1_ACC_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > OUT_MAX) v = OUT_MAX;
      if (v < OUT_MIN) v = OUT_MIN;
      return v;
   endfunction

   // Output/handshake/error checker
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         prev_valid = 1'b0;
      end else begin
         chk("tap_err", longint'(tap_err), longint'(exp_err));
         if (out_tvalid) chk("tready_while_out", longint'(prod_tready), 0);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", longint'(out_tvalid), 1);
            chk("hold_data", longint'($signed(out_tdata)), longint'($signed(prev_data)));
         end
         if (out_tvalid && out_tready) begin
            xfer_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
               fail("unexpected_output");
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_tdata", longint'($signed(out_tdata)), mon_e);
            end
            if (lat_chk) chk("latency", xfer_cyc - last_acc_cyc, 2);
         end
         prev_valid = out_tvalid;
         prev_ready = out_tready;
         prev_data  = out_tdata;
      end
   end

   // Product i is p0 for i==0, else base + i*step; bias held, then scrambled after tap 0
   task automatic send_window(input int bias, input int p0, input int base, input int step,
                              input int ntaps, input int tl_pos, input bit gaps,
                              input longint lit_plain, input longint lit_relu);
      longint sum;
      longint e;
      int     p;
      bit     rdy;
      int     guard;
      int     g;
      sum = longint'(bias);
      bias_data = BIAS_W'(bias);
      for (int i = 0; i < ntaps; i++) begin
         p = (i == 0) ? p0 : base + i * step;
         if (gaps) begin
            g = $urandom_range(0, 3);
            prod_tvalid = 1'b0;
            prod_tdata  = PROD_W'(24'h5A5A5A);
            repeat (g) begin
               @(posedge ap_clk);
               #1;
            end
         end
         prod_tdata  = PROD_W'(p);
         prod_tvalid = 1'b1;
         prod_tlast  = (i == tl_pos);
         rdy   = 1'b0;
         guard = 0;
         while (!rdy) begin
            @(negedge ap_clk);
            rdy = prod_tready;
            @(posedge ap_clk);
            #1;
            guard++;
            if (!rdy && guard > 200) begin
               fail("accept_timeout");
               prod_tvalid = 1'b0;
               return;
            end
         end
         if (i == 0) begin
            first_acc_cyc = cyc;
            bias_data = BIAS_W'(16'h7FFF);
         end
         last_acc_cyc = cyc;
         sum += longint'(p);
         if ((i == tl_pos) != (i == TAPS - 1)) exp_err = 1'b1;
      end
      prod_tvalid = 1'b0;
      prod_tlast  = 1'b0;
      if (ntaps == TAPS) begin
         e = model(sum);
`ifdef CNN_CONV1_ACC_RELU_EN
         chk("model_pin", e, lit_relu);
`else
         chk("model_pin", e, lit_plain);
`endif
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || out_tvalid) && guard < 200) begin
         @(posedge ap_clk);
         #1;
         guard++;
      end
      if (guard >= 200) fail("drain_timeout");
   endtask

   initial begin
      int guard;
      prod_tdata  = '0;
      prod_tvalid = 1'b0;
      prod_tlast  = 1'b0;
      bias_data   = '0;
      out_tready  = 1'b1;

      #2 ap_rst_n = 1'b0;
      #1;
      chk("rst_out_tdata", longint'(out_tdata), 0);
      chk("rst_out_tvalid", longint'(out_tvalid), 0);
      chk("rst_prod_tready", longint'(prod_tready), 0);
      chk("rst_tap_err", longint'(tap_err), 0);
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("tready_after_rst", longint'(prod_tready), 1);

      lat_chk = 1'b1;
      send_window(0, 256, 256, 0, TAPS, TAPS - 1, 1'b0, 25, 25);
      send_window(0, 384, 0, 0, TAPS, TAPS - 1, 1'b0, 2, 2);
      send_window(0, 383, 0, 0, TAPS, TAPS - 1, 1'b0, 1, 1);
      send_window(128, 0, 0, 0, TAPS, TAPS - 1, 1'b0, 1, 1);
      send_window(0, 4194304, 4194304, 0, TAPS, TAPS - 1, 1'b0, 8191, 8191);
      send_window(0, -4194304, -4194304, 0, TAPS, TAPS - 1, 1'b0, -8192, 0);
      send_window(0, -256, -256, 0, TAPS, TAPS - 1, 1'b0, -25, 0);
      send_window(300, -5000, -5000, 700, TAPS, TAPS - 1, 1'b0, 333, 333);
      send_window(0, 256, 256, 0, TAPS, TAPS - 1, 1'b1, 25, 25);
      send_window(300, -5000, -5000, 700, TAPS, TAPS - 1, 1'b1, 333, 333);
      drain();

      // Output backpressure, then immediate restart
      lat_chk = 1'b0;
      out_tready = 1'b0;
      send_window(0, 256, 256, 0, TAPS, TAPS - 1, 1'b0, 25, 25);
      guard = 0;
      while (!out_tvalid && guard < 50) begin
         @(negedge ap_clk);
         guard++;
      end
      if (!out_tvalid) fail("bp_valid_timeout");
      repeat (5) begin
         @(negedge ap_clk);
         chk("bp_prod_tready", longint'(prod_tready), 0);
         chk("bp_out_tvalid", longint'(out_tvalid), 1);
      end
      @(posedge ap_clk);
      #1;
      out_tready = 1'b1;
      send_window(0, -256, -256, 0, TAPS, TAPS - 1, 1'b0, -25, 0);
      chk("restart_gap", first_acc_cyc - xfer_cyc, 1);
      lat_chk = 1'b1;
      drain();

      // Early tlast: sticky error, counter still closes the window
      send_window(0, 256, 256, 0, TAPS, 10, 1'b0, 25, 25);
      drain();
      send_window(0, 384, 0, 0, TAPS, TAPS - 1, 1'b0, 2, 2);
      drain();

      // Reset mid-window discards the partial sum
      send_window(0, 256, 256, 0, 10, TAPS - 1, 1'b0, 0, 0);
      ap_rst_n = 1'b0;
      #1;
      exp_err = 1'b0;
      chk("mid_rst_out_tdata", longint'(out_tdata), 0);
      chk("mid_rst_out_tvalid", longint'(out_tvalid), 0);
      chk("mid_rst_prod_tready", longint'(prod_tready), 0);
      chk("mid_rst_tap_err", longint'(tap_err), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      send_window(0, 256, 256, 0, TAPS, TAPS - 1, 1'b0, 25, 25);
      drain();

      chk("pending_left", longint'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
